// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera capture front end.
package cam_pkg;

   typedef enum logic [1:0] {
      ST_SETTLE   = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_DROP     = 2'd3
   } cam_state_t;

   typedef logic [15:0] rgb565_t;

   localparam int unsigned H_PIXELS_DEF    = 640;
   localparam int unsigned V_LINES_DEF     = 480;
   localparam int unsigned SKIP_FRAMES_DEF = 10;

   localparam int unsigned PIX_W  = 11;
   localparam int unsigned LINE_W = 10;

   // Settle counter must hold the value SKIP_FRAMES itself.
   function automatic int unsigned settle_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// Byte-phase tracker: pairs consecutive valid bytes into one RGB565 word.
module cam_byte_pack
   import cam_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] data_byte,
   input  logic       valid,
   input  logic       clear,
   output rgb565_t    word,
   output logic       word_valid,
   output logic       odd_phase
);

   logic       phase;
   logic [7:0] hi_byte;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         phase   <= 1'b0;
         hi_byte <= 8'h00;
      end else if (clear) begin
         phase   <= 1'b0;
      end else if (valid) begin
         phase <= ~phase;
         if (!phase) hi_byte <= data_byte;
      end
   end

   // The word is formed combinationally on the low byte so the top can register it.
   assign word       = {hi_byte, data_byte};
   assign word_valid = valid & phase;
   assign odd_phase  = phase;

endmodule

// File: rtl/cam_capture.sv
// Camera capture: registers the OV7670-style bus, frames it and feeds RGB565 words
// to the SDRAM write FIFO, dropping any frame from the point it goes wrong.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_SETTLE   | counting vsync rises while the sensor settles after reset
// ST_WAIT_SOF | idle; waiting for vsync fall with capture enabled
// ST_ACTIVE   | capturing a frame, writing words to the FIFO
// ST_DROP     | frame failed; no writes until the frame ends
module cam_capture
   import cam_pkg::*;
#(
   parameter int unsigned H_PIXELS    = H_PIXELS_DEF,
   parameter int unsigned V_LINES     = V_LINES_DEF,
   parameter int unsigned SKIP_FRAMES = SKIP_FRAMES_DEF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        cam_vsync_i,
   input  logic        cam_href_i,
   input  logic [7:0]  cam_data_i,
   input  logic        capture_en_i,
   input  logic        fifo_full_i,
   output logic        fifo_wr_o,
   output logic [15:0] fifo_data_o,
   output logic        sof_o,
   output logic        eof_o,
   output logic [7:0]  frame_cnt_o,
   output logic        line_err_o,
   output logic        overflow_o
);

   localparam int unsigned         SET_W    = settle_width(SKIP_FRAMES);
   localparam logic [SET_W-1:0]    SKIP_CNT = SET_W'(SKIP_FRAMES);
   localparam logic [PIX_W-1:0]    H_CNT    = PIX_W'(H_PIXELS);
   localparam logic [LINE_W-1:0]   V_CNT    = LINE_W'(V_LINES);

   logic       vsync_r, vsync_q, href_r, href_q;
   logic [7:0] data_r;

   logic vsync_fall, vsync_rise, line_end, line_start;

   cam_state_t        state, state_nxt;
   logic [SET_W-1:0]  settle_cnt, settle_nxt;
   logic [PIX_W-1:0]  pix_cnt, pix_nxt;
   logic [LINE_W-1:0] line_cnt, line_nxt;
   logic [7:0]        frame_cnt;
   logic              line_err, overflow;
   logic              wr_q, sof_q, eof_q;
   rgb565_t           data_q;

   logic    wr_nxt, sof_nxt, eof_nxt, err_set, ovf_set;
   logic    pack_valid, pack_clear, word_valid, odd_phase;
   rgb565_t word;

   // vsync resets high so releasing reset during blanking is not seen as a frame end.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vsync_r <= 1'b1;
         vsync_q <= 1'b1;
         href_r  <= 1'b0;
         href_q  <= 1'b0;
         data_r  <= 8'h00;
      end else begin
         vsync_r <= cam_vsync_i;
         vsync_q <= vsync_r;
         href_r  <= cam_href_i;
         href_q  <= href_r;
         data_r  <= cam_data_i;
      end
   end

   assign vsync_fall = vsync_q & ~vsync_r;
   assign vsync_rise = ~vsync_q & vsync_r;
   assign line_end   = href_q & ~href_r;
   assign line_start = ~href_q & href_r;

   assign pack_valid = href_r & (state == ST_ACTIVE);

   cam_byte_pack u_pack (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .data_byte  (data_r),
      .valid      (pack_valid),
      .clear      (pack_clear),
      .word       (word),
      .word_valid (word_valid),
      .odd_phase  (odd_phase)
   );

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      pix_nxt    = pix_cnt;
      line_nxt   = line_cnt;
      wr_nxt     = 1'b0;
      sof_nxt    = 1'b0;
      eof_nxt    = 1'b0;
      err_set    = 1'b0;
      ovf_set    = 1'b0;
      pack_clear = 1'b1;
      unique case (state)
         ST_SETTLE: begin
            if (settle_cnt == SKIP_CNT) state_nxt = ST_WAIT_SOF;
            else if (vsync_rise) settle_nxt = settle_cnt + SET_W'(1);
         end
         ST_WAIT_SOF: begin
            if (vsync_fall && capture_en_i) begin
               state_nxt = ST_ACTIVE;
               sof_nxt   = 1'b1;
               pix_nxt   = '0;
               line_nxt  = '0;
            end
         end
         ST_ACTIVE: begin
            pack_clear = line_end;
            if (word_valid) begin
               if (fifo_full_i) begin
                  ovf_set   = 1'b1;
                  state_nxt = ST_DROP;
               end else begin
                  wr_nxt  = 1'b1;
                  pix_nxt = pix_cnt + PIX_W'(1);
               end
            end
            if (line_start && (line_cnt == V_CNT)) begin
               err_set   = 1'b1;
               state_nxt = ST_DROP;
            end
            if (line_end) begin
               if (odd_phase || (pix_cnt != H_CNT)) begin
                  err_set   = 1'b1;
                  state_nxt = ST_DROP;
               end else begin
                  line_nxt = line_cnt + LINE_W'(1);
                  pix_nxt  = '0;
               end
            end
            // Frame-end check sees the line count already updated by a same-cycle line end.
            if (vsync_rise) begin
               if (state_nxt != ST_DROP) begin
                  if (line_nxt == V_CNT) eof_nxt = 1'b1;
                  else                   err_set = 1'b1;
               end
               state_nxt = ST_WAIT_SOF;
            end
         end
         ST_DROP: begin
            if (vsync_rise) state_nxt = ST_WAIT_SOF;
         end
         default: state_nxt = ST_SETTLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= ST_SETTLE;
         settle_cnt <= '0;
         pix_cnt    <= '0;
         line_cnt   <= '0;
         frame_cnt  <= 8'h00;
         line_err   <= 1'b0;
         overflow   <= 1'b0;
         wr_q       <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         data_q     <= 16'h0000;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         pix_cnt    <= pix_nxt;
         line_cnt   <= line_nxt;
         line_err   <= line_err | err_set;
         overflow   <= overflow | ovf_set;
         wr_q       <= wr_nxt;
         sof_q      <= sof_nxt;
         eof_q      <= eof_nxt;
         if (wr_nxt)  data_q    <= word;
         if (eof_nxt) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign fifo_wr_o   = wr_q;
   assign fifo_data_o = data_q;
   assign sof_o       = sof_q;
   assign eof_o       = eof_q;
   assign frame_cnt_o = frame_cnt;
   assign line_err_o  = line_err;
   assign overflow_o  = overflow;

endmodule
